// File: rtl/fir_pkg.sv
// Shared definitions for the FIR engine: register map, bit positions, widths and FSM states.
package fir_pkg;

  localparam int unsigned NTAPS_MAX_DEF = 16;
  localparam int unsigned ACC_W         = 36;

  localparam logic [5:0] ADDR_CTRL      = 6'h00;
  localparam logic [5:0] ADDR_STATUS    = 6'h01;
  localparam logic [5:0] ADDR_NTAPS     = 6'h02;
  localparam logic [5:0] ADDR_SAMPLE_IN = 6'h03;
  localparam logic [5:0] ADDR_RESULT    = 6'h04;
  localparam logic [5:0] ADDR_COEF_BASE = 6'h10;

  localparam int unsigned CTRL_ENABLE   = 0;
  localparam int unsigned CTRL_CLR_HIST = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;

  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_DONE     = 1;
  localparam int unsigned STAT_OVERRUN  = 2;

  typedef enum logic [1:0] {IDLE, MAC, FINAL} fir_state_t;

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate with synchronous clear, plus a Q15 round-and-saturate output.
module fir_mac
  import fir_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_x,
  input  logic signed [DW-1:0] i_c,
  output logic        [DW-1:0] o_result
);

  localparam logic signed [ACC_W-1:0] RND =
    {{(ACC_W-DW+1){1'b0}}, 1'b1, {(DW-2){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACC_W-1:0] r_acc;
  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_rnd;
  logic signed [ACC_W-1:0] w_shift;

  assign w_prod = i_x * i_c;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  // Round half up, then arithmetic shift back to Q15.
  assign w_rnd   = r_acc + RND;
  assign w_shift = w_rnd >>> (DW-1);

  always_comb begin
    o_result = w_shift[DW-1:0];
    if (w_shift > SAT_MAX) begin
      o_result = SAT_MAX[DW-1:0];
    end else if (w_shift < SAT_MIN) begin
      o_result = SAT_MIN[DW-1:0];
    end
  end

endmodule

// File: rtl/fir_core.sv
// FIR engine: register file, sample delay line and a one-tap-per-cycle MAC sequencer.
module fir_core
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS_MAX = NTAPS_MAX_DEF,
  parameter int unsigned DW        = 16
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic [5:0]    p_address,
  input  logic [DW-1:0] p_data,
  input  logic          p_wr,
  output logic [DW-1:0] p_data_back,
  output logic          irq
);

  fir_state_t r_state, w_state_next;

  logic          r_enable, r_irq_en, r_done, r_overrun, r_irq;
  logic [4:0]    r_ntaps;
  logic [3:0]    r_idx;
  logic [DW-1:0] r_sample_in, r_result, r_rdata;
  logic [DW-1:0] r_coef [NTAPS_MAX];
  logic [DW-1:0] r_x    [NTAPS_MAX];

  logic          w_busy, w_wr_ctrl, w_wr_status, w_wr_ntaps, w_wr_sample, w_wr_coef;
  logic          w_coef_sel, w_clr_hist, w_start, w_drop, w_last, w_final;
  logic          w_mac_clr, w_mac_en;
  logic [DW-1:0] w_mac_result, w_rdata;

  assign w_busy      = (r_state != IDLE);
  assign w_coef_sel  = (p_address[5:4] == ADDR_COEF_BASE[5:4]) &&
                       (32'(p_address[3:0]) < NTAPS_MAX);
  assign w_wr_ctrl   = p_wr && (p_address == ADDR_CTRL);
  assign w_wr_status = p_wr && (p_address == ADDR_STATUS);
  assign w_wr_ntaps  = p_wr && (p_address == ADDR_NTAPS) && !w_busy &&
                       (p_data != '0) && (32'(p_data) <= NTAPS_MAX);
  assign w_wr_sample = p_wr && (p_address == ADDR_SAMPLE_IN);
  assign w_wr_coef   = p_wr && w_coef_sel && !w_busy;
  assign w_clr_hist  = w_wr_ctrl && p_data[CTRL_CLR_HIST];
  assign w_start     = w_wr_sample && r_enable && !w_busy && !w_clr_hist;
  assign w_drop      = w_wr_sample && w_busy;
  assign w_last      = ({1'b0, r_idx} == (r_ntaps - 5'd1));
  assign w_final     = (r_state == FINAL) && !w_clr_hist;

  always_comb begin
    w_state_next = r_state;
    w_mac_clr    = w_start || w_clr_hist;
    w_mac_en     = 1'b0;
    unique case (r_state)
      IDLE:  if (w_start) w_state_next = MAC;
      MAC: begin
        w_mac_en = !w_clr_hist;
        if (w_last) w_state_next = FINAL;
      end
      FINAL: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    // History clear aborts any computation in flight.
    if (w_clr_hist) w_state_next = IDLE;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_idx <= '0;
      end else if (r_state == MAC) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_enable    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_ntaps     <= 5'(NTAPS_MAX);
      r_sample_in <= '0;
      r_result    <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= p_data[CTRL_ENABLE];
        r_irq_en <= p_data[CTRL_IRQ_EN];
      end
      if (w_final) begin
        r_done <= 1'b1;
      end else if (w_wr_status && p_data[STAT_DONE]) begin
        r_done <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (w_wr_status && p_data[STAT_OVERRUN]) begin
        r_overrun <= 1'b0;
      end
      if (w_wr_ntaps) r_ntaps <= p_data[4:0];
      if (w_wr_sample) r_sample_in <= p_data;
      if (w_final) r_result <= w_mac_result;
      r_irq <= r_done && r_irq_en;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int k = 0; k < NTAPS_MAX; k++) begin
        r_coef[k] <= '0;
        r_x[k]    <= '0;
      end
    end else begin
      if (w_wr_coef) r_coef[p_address[3:0]] <= p_data;
      if (w_clr_hist) begin
        for (int k = 0; k < NTAPS_MAX; k++) r_x[k] <= '0;
      end else if (w_start) begin
        for (int k = NTAPS_MAX - 1; k > 0; k--) r_x[k] <= r_x[k-1];
        r_x[0] <= p_data;
      end
    end
  end

  fir_mac #(
    .DW(DW)
  ) u_mac (
    .i_clk    (PCLK),
    .i_rst_n  (PRESETn),
    .i_clr    (w_mac_clr),
    .i_en     (w_mac_en),
    .i_x      ($signed(r_x[r_idx])),
    .i_c      ($signed(r_coef[r_idx])),
    .o_result (w_mac_result)
  );

  always_comb begin
    w_rdata = '0;
    case (p_address)
      ADDR_CTRL: begin
        w_rdata[CTRL_ENABLE] = r_enable;
        w_rdata[CTRL_IRQ_EN] = r_irq_en;
      end
      ADDR_STATUS: begin
        w_rdata[STAT_BUSY]    = w_busy;
        w_rdata[STAT_DONE]    = r_done;
        w_rdata[STAT_OVERRUN] = r_overrun;
      end
      ADDR_NTAPS:     w_rdata[4:0] = r_ntaps;
      ADDR_SAMPLE_IN: w_rdata = r_sample_in;
      ADDR_RESULT:    w_rdata = r_result;
      default:        if (w_coef_sel) w_rdata = r_coef[p_address[3:0]];
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rdata;
    end
  end

  assign p_data_back = r_rdata;
  assign irq         = r_irq;

endmodule

// File: tb/tb_fir_core.sv
// Directed and randomized bench for fir_core against a plain-arithmetic FIR model.
module tb_fir_core;
  import fir_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic [5:0]  p_address = '0;
  logic [15:0] p_data = '0;
  logic        p_wr = 1'b0;
  logic [15:0] p_data_back;
  logic        irq;

  int checks = 0;
  int failures = 0;

  logic signed [15:0] m_x [16];
  logic signed [15:0] m_c [16];
  int                 m_ntaps;
  bit                 m_enable;
  logic [15:0]        rdv;

  fir_core #(
    .NTAPS_MAX (16),
    .DW        (16)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .p_address   (p_address),
    .p_data      (p_data),
    .p_wr        (p_wr),
    .p_data_back (p_data_back),
    .irq         (irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      m_x[k] = '0;
      m_c[k] = '0;
    end
    m_ntaps  = 16;
    m_enable = 1'b0;
  endtask

  function automatic logic [15:0] model_result();
    longint acc = 0;
    for (int k = 0; k < m_ntaps; k++) acc += longint'(m_x[k]) * longint'(m_c[k]);
    acc = (acc + 64'sd16384) >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    @(negedge PCLK);
    p_address = a;
    p_data    = d;
    p_wr      = 1'b1;
    @(negedge PCLK);
    p_wr      = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [15:0] d);
    @(negedge PCLK);
    p_address = a;
    @(negedge PCLK);
    d = p_data_back;
  endtask

  task automatic set_coef(input int k, input logic [15:0] v);
    m_c[k] = v;
    wr(ADDR_COEF_BASE + 6'(k), v);
  endtask

  // Sample write while the engine is idle; the model shifts only when enabled.
  task automatic push(input logic [15:0] d);
    if (m_enable) begin
      for (int k = 15; k > 0; k--) m_x[k] = m_x[k-1];
      m_x[0] = d;
    end
    wr(ADDR_SAMPLE_IN, d);
  endtask

  // Called on the negedge right after a write edge E0; the value seen at
  // iteration k was captured at edge Ek and reflects state after E(k-1).
  task automatic wait_done(input string tag, input bit chk_lat, input bit irq_on);
    bit   seen = 1'b0;
    int   lat = 0;
    logic prev_irq;
    p_address = ADDR_STATUS;
    prev_irq  = irq;
    for (int k = 1; k <= 40; k++) begin
      @(negedge PCLK);
      if (p_data_back[STAT_DONE]) begin
        seen = 1'b1;
        lat  = k - 1;
        break;
      end
      prev_irq = irq;
    end
    check({tag, " done"}, 16'(seen), 16'd1);
    if (seen && chk_lat) check({tag, " latency"}, 16'(lat), 16'(m_ntaps + 1));
    if (seen && irq_on) begin
      check({tag, " irq before"}, 16'(prev_irq), 16'd0);
      check({tag, " irq after"}, 16'(irq), 16'd1);
    end
  endtask

  task automatic run_sample(input string tag, input logic [15:0] d);
    push(d);
    wait_done(tag, 1'b1, 1'b0);
    rd(ADDR_RESULT, rdv);
    check({tag, " result"}, rdv, model_result());
    wr(ADDR_STATUS, 16'h0002);
  endtask

  initial begin
    model_reset();
    #1 PRESETn = 1'b0;
    #1;
    check("rst p_data_back", p_data_back, 16'h0000);
    check("rst irq", 16'(irq), 16'd0);
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;

    rd(ADDR_CTRL, rdv);      check("rst ctrl", rdv, 16'h0000);
    rd(ADDR_STATUS, rdv);    check("rst status", rdv, 16'h0000);
    rd(ADDR_NTAPS, rdv);     check("rst ntaps", rdv, 16'd16);
    rd(ADDR_SAMPLE_IN, rdv); check("rst sample_in", rdv, 16'h0000);
    rd(ADDR_RESULT, rdv);    check("rst result", rdv, 16'h0000);
    for (int k = 0; k < 16; k++) begin
      rd(ADDR_COEF_BASE + 6'(k), rdv);
      check($sformatf("rst coef%0d", k), rdv, 16'h0000);
    end

    // Impulse response through four taps.
    m_ntaps = 4;
    wr(ADDR_NTAPS, 16'd4);
    set_coef(0, 16'h4000);
    set_coef(1, 16'h2000);
    set_coef(2, 16'h1000);
    set_coef(3, 16'h0800);
    m_enable = 1'b1;
    wr(ADDR_CTRL, 16'h0001);
    rd(ADDR_NTAPS, rdv);     check("ntaps4", rdv, 16'd4);
    rd(ADDR_COEF_BASE + 6'd2, rdv); check("coef2 rb", rdv, 16'h1000);
    run_sample("imp0", 16'h7FFF);
    run_sample("imp1", 16'h0000);
    run_sample("imp2", 16'h0000);
    run_sample("imp3", 16'h0000);
    run_sample("imp4", 16'h0000);

    // Saturation in both directions.
    m_ntaps = 2;
    wr(ADDR_NTAPS, 16'd2);
    set_coef(0, 16'h7FFF);
    set_coef(1, 16'h7FFF);
    run_sample("satp0", 16'h7FFF);
    run_sample("satp1", 16'h7FFF);
    check("satp model", model_result(), 16'h7FFF);
    run_sample("satn0", 16'h8000);
    run_sample("satn1", 16'h8000);

    // Random tap counts, coefficients and samples.
    for (int r = 0; r < 3; r++) begin
      m_ntaps = $urandom_range(16, 1);
      wr(ADDR_NTAPS, 16'(m_ntaps));
      rd(ADDR_NTAPS, rdv);
      check("rnd ntaps", rdv, 16'(m_ntaps));
      for (int k = 0; k < 16; k++) set_coef(k, 16'($urandom));
      for (int s = 0; s < 5; s++) run_sample($sformatf("rnd%0d_%0d", r, s), 16'($urandom));
    end

    // Overrun: second sample lands two cycles after the first and is dropped.
    m_ntaps = 16;
    wr(ADDR_NTAPS, 16'd16);
    push(16'h1111);
    wr(ADDR_SAMPLE_IN, 16'h2222);
    rd(ADDR_STATUS, rdv);    check("ovr status busy", rdv, 16'h0005);
    wait_done("ovr", 1'b0, 1'b0);
    rd(ADDR_STATUS, rdv);    check("ovr status done", rdv, 16'h0006);
    rd(ADDR_RESULT, rdv);    check("ovr result", rdv, model_result());
    rd(ADDR_SAMPLE_IN, rdv); check("ovr sample_in", rdv, 16'h2222);
    wr(ADDR_STATUS, 16'h0004);
    rd(ADDR_STATUS, rdv);    check("ovr w1c overrun", rdv, 16'h0002);
    wr(ADDR_STATUS, 16'h0002);
    rd(ADDR_STATUS, rdv);    check("ovr w1c done", rdv, 16'h0000);

    // History clear aborts a computation in flight.
    push(16'h3456);
    @(negedge PCLK);
    wr(ADDR_CTRL, 16'h0003);
    for (int k = 0; k < 16; k++) m_x[k] = '0;
    p_address = ADDR_STATUS;
    @(negedge PCLK);
    check("clr status", p_data_back, 16'h0000);
    rd(ADDR_CTRL, rdv);      check("clr ctrl", rdv, 16'h0001);
    run_sample("clr imp", 16'h7FFF);

    // Ignored writes: bad NTAPS, undefined address, config while busy.
    wr(ADDR_NTAPS, 16'd0);
    rd(ADDR_NTAPS, rdv);     check("ntaps0 ignored", rdv, 16'd16);
    wr(ADDR_NTAPS, 16'd17);
    rd(ADDR_NTAPS, rdv);     check("ntaps17 ignored", rdv, 16'd16);
    wr(6'h3F, 16'hBEEF);
    rd(6'h3F, rdv);          check("undef addr", rdv, 16'h0000);
    push(16'h0F0F);
    wr(ADDR_COEF_BASE + 6'd1, 16'h1234);
    wr(ADDR_NTAPS, 16'd3);
    wait_done("busy cfg", 1'b0, 1'b0);
    rd(ADDR_COEF_BASE + 6'd1, rdv); check("busy coef ignored", rdv, m_c[1]);
    rd(ADDR_NTAPS, rdv);     check("busy ntaps ignored", rdv, 16'd16);
    rd(ADDR_RESULT, rdv);    check("busy cfg result", rdv, model_result());
    wr(ADDR_STATUS, 16'h0002);

    // Interrupt follows done one cycle later and drops after W1C.
    wr(ADDR_CTRL, 16'h0005);
    push(16'h0100);
    wait_done("irq", 1'b1, 1'b1);
    wr(ADDR_STATUS, 16'h0002);
    check("irq hold", 16'(irq), 16'd1);
    @(negedge PCLK);
    check("irq drop", 16'(irq), 16'd0);

    // Reset mid-computation.
    push(16'h1357);
    repeat (3) @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    check("mid rst p_data_back", p_data_back, 16'h0000);
    check("mid rst irq", 16'(irq), 16'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    model_reset();
    rd(ADDR_STATUS, rdv);    check("mid rst status", rdv, 16'h0000);
    rd(ADDR_CTRL, rdv);      check("mid rst ctrl", rdv, 16'h0000);
    rd(ADDR_NTAPS, rdv);     check("mid rst ntaps", rdv, 16'd16);
    rd(ADDR_RESULT, rdv);    check("mid rst result", rdv, 16'h0000);
    rd(ADDR_SAMPLE_IN, rdv); check("mid rst sample_in", rdv, 16'h0000);
    rd(ADDR_COEF_BASE, rdv); check("mid rst coef0", rdv, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
